// File: rtl/naive_bus_ram_slave_if.sv
// naive_bus: request/grant memory bus with independent read and write channels.
//   rd_req/rd_be/rd_addr -> rd_gnt/rd_data   (read channel, data one cycle after grant)
//   wr_req/wr_be/wr_addr/wr_data -> wr_gnt  (write channel)
interface naive_bus;
  logic        rd_req;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );
endinterface

// File: rtl/naive_bus_ram_slave.sv
// naive_bus_ram_slave: word-organised RAM behind a naive_bus responder port.
// Reads win over writes; an optional stall of WAIT_CYCLES cycles precedes every
// grant. Read data is registered at the granting edge and held until the next
// granted read. Addresses above the RAM are granted but read as 0 / drop writes.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset (RAM contents are kept)
//   bus_slave : naive_bus.slave port
module naive_bus_ram_slave #(
  parameter int unsigned ADDR_LEN    = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic     clk,
  input logic     rst,
  naive_bus.slave bus_slave
);

  localparam int unsigned WORDS  = 1 << ADDR_LEN;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                lat_rd, lat_rd_nxt;
  logic [31:0]         lat_addr, lat_addr_nxt;

  logic                req_c;
  logic                req_rd_c;
  logic [31:0]         req_addr_c;
  logic                match_c;
  logic                restart_c;
  logic                gnt_c;
  logic                rd_gnt_c;
  logic                wr_gnt_c;
  logic                in_range_c;
  logic [ADDR_LEN-1:0] word_c;
  logic [DATA_W-1:0]   rd_mask_c;

  logic [DATA_W-1:0]   mem [WORDS];
  logic [DATA_W-1:0]   rd_data_q;

  // Current request as seen by the arbiter: a read hides a concurrent write.
  assign req_c      = bus_slave.rd_req | bus_slave.wr_req;
  assign req_rd_c   = bus_slave.rd_req;
  assign req_addr_c = req_rd_c ? bus_slave.rd_addr : bus_slave.wr_addr;
  assign match_c    = req_c && (req_rd_c == lat_rd) && (req_addr_c == lat_addr);

  // Word decode; any bit above the RAM makes the access out of range.
  assign word_c     = req_addr_c[ADDR_LEN+1:2];
  assign in_range_c = (req_addr_c >> (ADDR_LEN + 2)) == 32'd0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_rd   <= 1'b0;
      lat_addr <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_rd   <= lat_rd_nxt;
      lat_addr <= lat_addr_nxt;
    end
  end

  // Next state and grant. A request that changes or vanishes mid-stall is
  // discarded and the current inputs are re-evaluated as if from IDLE.
  // The IDLE cycle counts as the first stall cycle, so entry from IDLE loads
  // WAIT_CYCLES-1 (going straight to GRANT for a single stall cycle), while a
  // back-to-back request from GRANT needs the full WAIT_CYCLES in WAIT.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_rd_nxt   = lat_rd;
    lat_addr_nxt = lat_addr;
    gnt_c        = 1'b0;
    restart_c    = 1'b0;
    if (WAIT_CYCLES == 0) begin
      gnt_c = req_c;
    end else begin
      unique case (state)
        IDLE: restart_c = 1'b1;
        WAIT: begin
          if (!match_c) begin
            restart_c = 1'b1;
          end else if (cnt <= CNT_W'(1)) begin
            state_nxt = GRANT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        GRANT: begin
          if (!match_c) begin
            restart_c = 1'b1;
          end else begin
            gnt_c     = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
          end
        end
        default: restart_c = 1'b1;
      endcase
      if (restart_c) begin
        if (req_c) begin
          lat_rd_nxt   = req_rd_c;
          lat_addr_nxt = req_addr_c;
          if (WAIT_CYCLES == 1) begin
            state_nxt = GRANT;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
    end
  end

  // Grants are suppressed for as long as reset is held.
  assign rd_gnt_c = gnt_c & req_rd_c & ~rst;
  assign wr_gnt_c = gnt_c & ~req_rd_c & ~rst;

  // Byte-lane mask for read data.
  always_comb begin
    rd_mask_c = '0;
    for (int b = 0; b < BE_W; b++) begin
      rd_mask_c[8*b +: 8] = {8{bus_slave.rd_be[b]}};
    end
  end

  // RAM write port; never reset.
  always_ff @(posedge clk) begin
    if (wr_gnt_c && in_range_c) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus_slave.wr_be[b]) begin
          mem[word_c][8*b +: 8] <= bus_slave.wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read data register, loaded only at a granting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_gnt_c) begin
      rd_data_q <= in_range_c ? (mem[word_c] & rd_mask_c) : '0;
    end
  end

  assign bus_slave.rd_gnt  = rd_gnt_c;
  assign bus_slave.wr_gnt  = wr_gnt_c;
  assign bus_slave.rd_data = rd_data_q;

endmodule

// File: tb/tb_naive_bus_ram_slave.sv
// Bench for naive_bus_ram_slave: a zero-stall and a two-stall instance share
// one stimulus stream; each is tracked by a request-stability reference model,
// plus a constant-expectation vector table and hand sequences.
module tb_naive_bus_ram_slave;

  localparam int unsigned AL    = 8;
  localparam int unsigned WORDS = 1 << AL;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [3:0]  rd_be, wr_be;
  logic [31:0] rd_addr, wr_addr, wr_data;

  always #5 clk = ~clk;

  naive_bus bus0 ();
  naive_bus bus2 ();

  assign bus0.rd_req  = rd_req;
  assign bus0.rd_be   = rd_be;
  assign bus0.rd_addr = rd_addr;
  assign bus0.wr_req  = wr_req;
  assign bus0.wr_be   = wr_be;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus2.rd_req  = rd_req;
  assign bus2.rd_be   = rd_be;
  assign bus2.rd_addr = rd_addr;
  assign bus2.wr_req  = wr_req;
  assign bus2.wr_be   = wr_be;
  assign bus2.wr_addr = wr_addr;
  assign bus2.wr_data = wr_data;

  naive_bus_ram_slave #(.ADDR_LEN(AL), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus_slave(bus0));
  naive_bus_ram_slave #(.ADDR_LEN(AL), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus_slave(bus2));

  logic        act_rg [2];
  logic        act_wg [2];
  logic [31:0] act_rd [2];
  assign act_rg[0] = bus0.rd_gnt;
  assign act_wg[0] = bus0.wr_gnt;
  assign act_rd[0] = bus0.rd_data;
  assign act_rg[1] = bus2.rd_gnt;
  assign act_wg[1] = bus2.wr_gnt;
  assign act_rd[1] = bus2.rd_data;

  // Reference model state, one slot per instance.
  logic [31:0] mem_m [2][WORDS];
  logic [31:0] exp_rd [2];
  int          run [2];
  logic        prev_rd [2];
  logic [31:0] prev_addr [2];

  // Outputs sampled at the most recent negedge.
  logic        s_rg [2];
  logic        s_wg [2];
  logic [31:0] s_rd [2];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rd_req;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        e_rg;
    logic        e_wg;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0400;
    else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic set_in(input logic rr, input logic [3:0] rb, input logic [31:0] ra,
                        input logic wr, input logic [3:0] wb, input logic [31:0] wa,
                        input logic [31:0] wd);
    rd_req  = rr;
    rd_be   = rb;
    rd_addr = ra;
    wr_req  = wr;
    wr_be   = wb;
    wr_addr = wa;
    wr_data = wd;
  endtask

  // One clock: sample and check both instances at negedge, advance the model
  // across the following posedge. A request is granted once the same
  // (type, address) has been presented for WAIT+1 consecutive cycles since the
  // last grant, reset, or change.
  task automatic cycle();
    logic          req, is_rd, g, in_rng;
    logic [31:0]   a;
    logic [AL-1:0] wi;
    int            r, n;
    @(negedge clk);
    req    = rd_req | wr_req;
    is_rd  = rd_req;
    a      = is_rd ? rd_addr : wr_addr;
    in_rng = (a >> (AL + 2)) == 32'd0;
    wi     = a[AL+1:2];
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 0 : 2;
      s_rg[k] = act_rg[k];
      s_wg[k] = act_wg[k];
      s_rd[k] = act_rd[k];
      if (rst) exp_rd[k] = '0;
      if (rst || !req) r = 0;
      else if (run[k] > 0 && prev_rd[k] == is_rd && prev_addr[k] == a) r = run[k] + 1;
      else r = 1;
      g = (r == n + 1);
      check($sformatf("w%0d rd_gnt", n), 32'(s_rg[k]), 32'(g && is_rd));
      check($sformatf("w%0d wr_gnt", n), 32'(s_wg[k]), 32'(g && !is_rd));
      check($sformatf("w%0d rd_data", n), s_rd[k], exp_rd[k]);
      if (g) begin
        if (is_rd) exp_rd[k] = in_rng ? (mem_m[k][wi] & be_mask(rd_be)) : '0;
        else if (in_rng)
          mem_m[k][wi] = (mem_m[k][wi] & ~be_mask(wr_be)) | (wr_data & be_mask(wr_be));
      end
      run[k]       = g ? 0 : r;
      prev_rd[k]   = is_rd;
      prev_addr[k] = a;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b1, 4'hF, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      exp_rd[k]    = '0;
      run[k]       = 0;
      prev_rd[k]   = 1'b0;
      prev_addr[k] = '0;
    end

    // Constant-expectation vectors for the zero-stall instance.
    tv[0]  = '{1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b0, 1'b1, 32'h0};
    tv[1]  = '{1'b1, 4'hF, 32'h10,       1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tv[3]  = '{1'b0, 4'h0, 32'h0,        1'b1, 4'h1, 32'h10,       32'h000000AA, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[4]  = '{1'b1, 4'h3, 32'h10,       1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    tv[5]  = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000BEAA};
    tv[6]  = '{1'b1, 4'hF, 32'h10,       1'b1, 4'hF, 32'h14,       32'h12345678, 1'b1, 1'b0, 32'h0000BEAA};
    tv[7]  = '{1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 32'h14,       32'h12345678, 1'b0, 1'b1, 32'hDEADBEAA};
    tv[8]  = '{1'b1, 4'hC, 32'h14,       1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEAA};
    tv[9]  = '{1'b1, 4'hF, 32'hFFFF0000, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h12340000};
    tv[10] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    tv[11] = '{1'b0, 4'h0, 32'h0,        1'b1, 4'hF, 32'hFFFF0010, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
    tv[12] = '{1'b1, 4'hF, 32'h10,       1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
    tv[13] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEAA};
    tv[14] = '{1'b1, 4'h2, 32'h13,       1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEAA};
    tv[15] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0000BE00};
    tv[16] = '{1'b1, 4'hF, 32'h410,      1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0000BE00};
    tv[17] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};

    // Reset state, with a read request present that must not be granted.
    cycle();
    for (int k = 0; k < 2; k++) begin
      check("reset rd_gnt", 32'(s_rg[k]), 32'h0);
      check("reset wr_gnt", 32'(s_wg[k]), 32'h0);
      check("reset rd_data", s_rd[k], 32'h0);
    end
    cycle();
    rst = 1'b0;

    // Fill every word so later reads are fully defined.
    for (int w = 0; w < int'(WORDS); w++) begin
      set_in(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'(w) << 2, $urandom);
      repeat (3) cycle();
    end

    // Reset pulse: rd_data cleared, RAM kept.
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      set_in(tv[i].rd_req, tv[i].rd_be, tv[i].rd_addr, tv[i].wr_req, tv[i].wr_be,
             tv[i].wr_addr, tv[i].wr_data);
      cycle();
      check($sformatf("tbl%0d rd_gnt", i), 32'(s_rg[0]), 32'(tv[i].e_rg));
      check($sformatf("tbl%0d wr_gnt", i), 32'(s_wg[0]), 32'(tv[i].e_wg));
      check($sformatf("tbl%0d rd_data", i), s_rd[0], tv[i].e_rd);
    end

    // Two-stall instance: held requests are granted every third cycle.
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    set_in(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h20, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stallA wr_gnt c%0d", i), 32'(s_wg[1]), 32'(i == 2));
    end
    set_in(1'b1, 4'hF, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      cycle();
      check($sformatf("stallA rd_gnt c%0d", i), 32'(s_rg[1]), 32'(i == 2 || i == 5));
      if (i >= 3) check($sformatf("stallA rd_data c%0d", i), s_rd[1], 32'h11223344);
    end

    // Address change mid-stall restarts the wait for the new address.
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    set_in(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h24, 32'h55667788);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stallB wr_gnt c%0d", i), 32'(s_wg[1]), 32'(i == 2));
    end
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    set_in(1'b1, 4'hF, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("stallB old rd_gnt c%0d", i), 32'(s_rg[1]), 32'h0);
    end
    set_in(1'b1, 4'hF, 32'h24, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("stallB new rd_gnt c%0d", i), 32'(s_rg[1]), 32'(i == 2));
      if (i == 3) check("stallB rd_data", s_rd[1], 32'h55667788);
    end

    // Reset during a stalled write: no grant, no RAM update, rd_data cleared.
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    set_in(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5);
    cycle();
    check("stallC wr_gnt pre", 32'(s_wg[1]), 32'h0);
    rst = 1'b1;
    cycle();
    check("stallC rst wr_gnt", 32'(s_wg[1]), 32'h0);
    check("stallC rst rd_data", s_rd[1], 32'h0);
    rst = 1'b0;
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    check("stallC post rd_data", s_rd[1], 32'h0);
    set_in(1'b1, 4'hF, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stallC rd_gnt c%0d", i), 32'(s_rg[1]), 32'(i == 2));
    end
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    check("stallC ram kept", s_rd[1], 32'h11223344);

    // Random traffic with sticky requests and occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 35) begin
        rd_req  = 1'($urandom_range(0, 1));
        wr_req  = 1'($urandom_range(0, 1));
        rd_be   = 4'($urandom);
        wr_be   = 4'($urandom);
        rd_addr = rand_addr();
        wr_addr = rand_addr();
        wr_data = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    set_in(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
